// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: port IDs, NOP data, tag layout.
package inst_mem_arbiter_pkg;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_LOADER = 1'b1} port_e;

  localparam logic [31:0] NOP_RDATA = 32'h0;
  localparam int          WRCNT_W   = 16;

  typedef struct packed {
    logic  vld;
    port_e port;
    logic  err;
  } tag_t;
endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface inst_mem_arbiter_if #(parameter int IROM_SPACE = 4096);
  localparam int AW = $clog2(IROM_SPACE);

  logic          f_valid, f_ready, f_rvalid, f_err;
  logic [31:0]   f_addr, f_rdata;
  logic          l_valid, l_ready, l_rvalid, l_err;
  logic [3:0]    l_we;
  logic [31:0]   l_addr, l_wdata, l_rdata;
  logic          mem_cs;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  modport slave (
    input  f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
    output f_ready, f_rvalid, f_rdata, f_err, l_ready, l_rvalid, l_rdata, l_err,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output f_valid, f_addr, l_valid, l_we, l_addr, l_wdata, mem_rdata,
    input  f_ready, f_rvalid, f_rdata, f_err, l_ready, l_rvalid, l_rdata, l_err,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_arbiter_rr_arb2.sv
// 2-way round-robin arbiter; bit 0 = fetch, bit 1 = loader. Fetch wins the first tie.
module rr_arb2
  import inst_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  port_e last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last == PORT_LOADER) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)         last <= PORT_LOADER;
    else if (gnt[0]) last <= PORT_FETCH;
    else if (gnt[1]) last <= PORT_LOADER;
  end
endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares the single-port instruction RAM between core fetch and the loader/debug port.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int IROM_SPACE = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  inst_mem_arbiter_if.slave  bus,
  output logic [WRCNT_W-1:0] wr_count
);
  localparam int AW = $clog2(IROM_SPACE);

  logic       f_oor, l_oor, l_rd, l_wr, wr_err, rsp_vld;
  logic [1:0] req, gnt;
  logic [31:0] rsp_data;
  tag_t       tag;

  assign f_oor = |bus.f_addr[31:AW+2];
  assign l_oor = |bus.l_addr[31:AW+2];

  // Masking requests with rst keeps every grant-derived output at 0 during reset.
  assign req = {bus.l_valid & ~rst, bus.f_valid & fetch_en & ~rst};

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));

  assign bus.f_ready = gnt[0];
  assign bus.l_ready = gnt[1];
  assign l_rd = gnt[1] & (bus.l_we == 4'h0);
  assign l_wr = gnt[1] & (bus.l_we != 4'h0);

  always_comb begin
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = NOP_RDATA;
    if (gnt[1]) begin
      bus.mem_addr = bus.l_addr[AW+1:2];
      if (!l_oor) begin
        bus.mem_cs    = 1'b1;
        bus.mem_we    = bus.l_we;
        bus.mem_wdata = bus.l_wdata;
      end
    end else if (!rst) begin
      bus.mem_addr = bus.f_addr[AW+1:2];
      bus.mem_cs   = gnt[0] & ~f_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag      <= '{vld: 1'b0, port: PORT_FETCH, err: 1'b0};
      wr_err   <= 1'b0;
      wr_count <= '0;
    end else begin
      tag.vld  <= gnt[0] | l_rd;
      tag.port <= gnt[1] ? PORT_LOADER : PORT_FETCH;
      tag.err  <= gnt[1] ? l_oor : f_oor;
      wr_err   <= l_wr & l_oor;
      if (l_wr && !l_oor && wr_count != {WRCNT_W{1'b1}})
        wr_count <= wr_count + 1'b1;
    end
  end

  // Gating with rst drops a response whose read was accepted just before reset.
  assign rsp_vld      = tag.vld & ~rst;
  assign rsp_data     = (rsp_vld && !tag.err) ? bus.mem_rdata : NOP_RDATA;
  assign bus.f_rvalid = rsp_vld & (tag.port == PORT_FETCH);
  assign bus.l_rvalid = rsp_vld & (tag.port == PORT_LOADER);
  assign bus.f_rdata  = bus.f_rvalid ? rsp_data : NOP_RDATA;
  assign bus.l_rdata  = bus.l_rvalid ? rsp_data : NOP_RDATA;
  assign bus.f_err    = bus.f_rvalid & tag.err;
  assign bus.l_err    = (bus.l_rvalid & tag.err) | (wr_err & ~rst);
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_inst_mem_arbiter;
  logic        clk, rst, fetch_en;
  logic [15:0] wr_count;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        err;
    logic        wr;
  } exp_t;
  exp_t fq[$];
  exp_t lq[$];

  logic [31:0] mem [0:4095];

  inst_mem_arbiter_if #(.IROM_SPACE(4096)) bus ();
  inst_mem_arbiter #(.IROM_SPACE(4096)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .bus(bus), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.f_rvalid) begin
      if (fq.size() == 0) chk("f_unexpected_rvalid", 1, 0);
      else begin
        e = fq.pop_front();
        chk("f_rdata", bus.f_rdata, e.d);
        chk("f_err", {31'b0, bus.f_err}, {31'b0, e.err});
      end
    end
    if (bus.l_rvalid || bus.l_err) begin
      if (lq.size() == 0) chk("l_unexpected_rsp", 1, 0);
      else begin
        e = lq.pop_front();
        chk("l_rvalid", {31'b0, bus.l_rvalid}, {31'b0, ~e.wr});
        chk("l_rdata", bus.l_rdata, e.d);
        chk("l_err", {31'b0, bus.l_err}, {31'b0, e.err});
      end
    end
    if (bus.f_rvalid || bus.l_rvalid)
      chk("single_rvalid", {31'b0, bus.f_rvalid & bus.l_rvalid}, 0);
  end

  // One request cycle; ef/el are the expected grants, ed/eerr the expected response.
  task automatic cyc(input logic fv, input logic [31:0] fa,
                     input logic lv, input logic [3:0] lwe, input logic [31:0] la,
                     input logic [31:0] lwd,
                     input logic ef, input logic el, input logic ecs,
                     input logic [3:0] ewe, input logic [11:0] eaddr,
                     input logic [31:0] ed, input logic eerr);
    bus.f_valid = fv; bus.f_addr = fa;
    bus.l_valid = lv; bus.l_we = lwe; bus.l_addr = la; bus.l_wdata = lwd;
    #1;
    chk("f_ready", {31'b0, bus.f_ready}, {31'b0, ef});
    chk("l_ready", {31'b0, bus.l_ready}, {31'b0, el});
    chk("mem_cs", {31'b0, bus.mem_cs}, {31'b0, ecs});
    chk("mem_we", {28'b0, bus.mem_we}, {28'b0, ewe});
    if (ecs) chk("mem_addr", {20'b0, bus.mem_addr}, {20'b0, eaddr});
    if (ef && fv) fq.push_back('{d: ed, err: eerr, wr: 1'b0});
    if (el && lv) begin
      if (lwe == 4'h0)  lq.push_back('{d: ed, err: eerr, wr: 1'b0});
      else if (eerr)    lq.push_back('{d: 32'h0, err: 1'b1, wr: 1'b1});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.f_valid = 1'b0; bus.l_valid = 1'b0; bus.l_we = 4'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    rst = 1'b1; fetch_en = 1'b1;
    bus.f_valid = 1'b1; bus.f_addr = 32'h0;
    bus.l_valid = 1'b1; bus.l_we = 4'h0; bus.l_addr = 32'h0; bus.l_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_ready", {31'b0, bus.f_ready}, 0);
    chk("rst_l_ready", {31'b0, bus.l_ready}, 0);
    chk("rst_mem_cs", {31'b0, bus.mem_cs}, 0);
    rst = 1'b0; bus.f_valid = 1'b0; bus.l_valid = 1'b0;
    #1;
    chk("rst_wr_count", {16'b0, wr_count}, 0);
    chk("rst_f_rvalid", {31'b0, bus.f_rvalid}, 0);
    chk("rst_l_rvalid", {31'b0, bus.l_rvalid}, 0);
    chk("rst_l_err", {31'b0, bus.l_err}, 0);

    // Fetch-only stream, back-to-back
    cyc(1, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 4'h0, 12'd0, 32'hA000_0000, 0);
    cyc(1, 32'h4, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 4'h0, 12'd1, 32'hA000_0001, 0);
    cyc(1, 32'h8, 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 4'h0, 12'd2, 32'hA000_0002, 0);
    idle();

    // Loader owns memory while fetch is disabled
    fetch_en = 1'b0;
    cyc(1, 32'h20, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0, 1, 1, 4'hF, 12'd4, 32'h0, 0);
    chk("wr_count_1", {16'b0, wr_count}, 1);
    cyc(1, 32'h20, 1, 4'h0, 32'h10, 32'h0, 0, 1, 1, 4'h0, 12'd4, 32'hDEAD_BEEF, 0);
    cyc(1, 32'h20, 1, 4'h3, 32'h14, 32'h1234_5678, 0, 1, 1, 4'h3, 12'd5, 32'h0, 0);
    cyc(0, 32'h0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 1, 4'h0, 12'd5, 32'hA000_5678, 0);
    chk("wr_count_2", {16'b0, wr_count}, 2);
    idle();

    // Out-of-range write then read
    fetch_en = 1'b1;
    cyc(0, 32'h0, 1, 4'hF, 32'h0000_4000, 32'h5555_5555, 0, 1, 0, 4'h0, 12'd0, 32'h0, 1);
    chk("wr_count_oor", {16'b0, wr_count}, 2);
    cyc(1, 32'h0000_4000, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 4'h0, 12'd0, 32'h0, 1);
    cyc(0, 32'h0, 1, 4'h0, 32'h8000_0000, 32'h0, 0, 1, 0, 4'h0, 12'd0, 32'h0, 1);
    idle();

    // Round-robin after reset: F,L,F,L
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    cyc(1, 32'h0, 1, 4'h0, 32'h8, 32'h0, 1, 0, 1, 4'h0, 12'd0, 32'hA000_0000, 0);
    cyc(1, 32'h4, 1, 4'h0, 32'h8, 32'h0, 0, 1, 1, 4'h0, 12'd2, 32'hA000_0002, 0);
    cyc(1, 32'h4, 1, 4'h0, 32'hC, 32'h0, 1, 0, 1, 4'h0, 12'd1, 32'hA000_0001, 0);
    cyc(1, 32'h8, 1, 4'h0, 32'hC, 32'h0, 0, 1, 1, 4'h0, 12'd3, 32'hA000_0003, 0);
    idle();

    // Reset right after an accepted fetch drops its response
    bus.f_valid = 1'b1; bus.f_addr = 32'h0;
    #1; chk("pre_rst_f_ready", {31'b0, bus.f_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.l_valid = 1'b1; bus.l_addr = 32'h4;
    #1;
    chk("rst_drop_f_rvalid", {31'b0, bus.f_rvalid}, 0);
    chk("rst_mid_f_ready", {31'b0, bus.f_ready}, 0);
    chk("rst_mid_l_ready", {31'b0, bus.l_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1; chk("post_rst_f_rvalid", {31'b0, bus.f_rvalid}, 0);
    cyc(1, 32'h0, 1, 4'h0, 32'h4, 32'h0, 1, 0, 1, 4'h0, 12'd0, 32'hA000_0000, 0);
    idle();
    chk("wr_count_after_rst", {16'b0, wr_count}, 0);

    // Saturation of the write counter
    bus.l_valid = 1'b1; bus.l_we = 4'hF; bus.l_addr = 32'h400; bus.l_wdata = 32'h0;
    repeat (65535) @(posedge clk);
    #1; chk("wr_count_max", {16'b0, wr_count}, 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("wr_count_sat", {16'b0, wr_count}, 32'h0000_FFFF);
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("fq_drained", fq.size(), 0);
    chk("lq_drained", lq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
Shares the single-port instruction memory (1-cycle synchronous read, byte-write enables) between two requesters: the core fetch port (read-only) and a program loader/debug port (read/write). One access is granted per cycle. The block drives the memory's chip-select, write-enable, address and write data, and routes read data back to the requester that issued the read. It sits between the core/loader and inst_memory's RAM instance. A fetch-enable input holds the core off the memory while a program is loaded.

Parameters:
IROM_SPACE, 4096, memory depth in 32-bit words; power of two
AW, $clog2(IROM_SPACE), word-address width (localparam, not overridable)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
fetch_en  in  1  1 = fetch port may be granted; 0 = fetch requests stall
f_valid  in  1  fetch read request
f_ready  out  1  fetch request accepted this cycle (combinational)
f_addr  in  32  fetch byte address
f_rvalid  out  1  fetch read data valid
f_rdata  out  32  fetch read data
f_err  out  1  qualifies f_rvalid: address out of range, f_rdata = 0
l_valid  in  1  loader request
l_ready  out  1  loader request accepted this cycle (combinational)
l_we  in  4  byte write enables; 0 = read
l_addr  in  32  loader byte address
l_wdata  in  32  loader write data
l_rvalid  out  1  loader read data valid (reads only)
l_rdata  out  32  loader read data
l_err  out  1  qualifies l_rvalid / flags a dropped out-of-range write
mem_cs  out  1  memory chip select
mem_we  out  4  memory byte write enables
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid 1 cycle after a cs=1 read
wr_count  out  16  number of accepted in-range loader writes, saturating

Behaviour:
- Reset (rst=1 at a clock edge): f_rvalid, l_rvalid, f_err, l_err = 0; wr_count = 0; pending-read tag cleared; rr_last = LOADER, so fetch wins the first tie. mem_* and *_ready are combinational and are 0 while rst=1.
- Eligibility: fetch_elig = f_valid & fetch_en; load_elig = l_valid.
- Arbitration is round-robin on ties. When only one requester is eligible, it is granted. When both are eligible, the requester not granted last wins. rr_last updates on every grant.
- Grant is combinational: f_ready / l_ready = grant. A request is accepted when valid & ready are both high. Requesters hold their request stable until accepted.
- Address: word address = addr[AW+1:2]. addr[1:0] is ignored. The address is out of range if addr[31:AW+2] != 0.
- In-range grant: mem_cs = 1, mem_addr = word address. mem_we = l_we for the loader and 0 for fetch. mem_wdata = l_wdata, or 0 for fetch.
- Out-of-range grant: still accepted (ready=1), but mem_cs = 0 and mem_we = 0. For a read, the response arrives next cycle with err=1 and rdata=0. For a write, l_err pulses for 1 cycle with l_rvalid=0, and wr_count is not incremented.
- Read latency: accepted in cycle N, so *_rvalid=1 in cycle N+1 with rdata = mem_rdata. A registered tag {port, err} selects the destination. Responses have no back-pressure; the requester must accept them.
- Writes produce no rvalid. wr_count increments on each accepted in-range write with l_we != 0, and saturates at 16'hFFFF.
- Back-to-back: a new grant is allowed every cycle, including in the cycle a response is returned.
- fetch_en=0 with a fetch request pending: f_ready=0. The loader gets every cycle. rr_last is not updated for fetch.
- Reset mid-operation: an in-flight read's response is dropped, so rvalid=0 in the cycle after reset.
- Idle (no eligible request): mem_cs=0, mem_we=0, mem_addr holds its previous value (don't-care).

Decomposition:
- Shared package/defines header holds: port IDs (PORT_FETCH=0, PORT_LOADER=1), the NOP/error read value (32'h0), and the width of the wr_count field.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (req[1:0], gnt[1:0], last-grant register, synchronous active-high reset).
- The address check, tag register and response routing stay in the top module.

Test Plan:
- Fetch only, fetch_en=1, addr 0x0,0x4,0x8 in consecutive cycles -> f_ready=1 each cycle; f_rvalid one cycle later with mem contents of words 0,1,2; l_rvalid=0 throughout.
- fetch_en=0, loader writes 0xDEADBEEF (we=4'hF) to 0x10 while f_valid=1 -> f_ready=0; mem_we=4'hF at word 4; wr_count=1; then loader read 0x10 -> l_rdata=0xDEADBEEF, l_err=0.
- Both valid for 4 consecutive cycles after reset -> grants F,L,F,L; each rvalid routed to the correct port, never both in the same cycle.
- Loader write to 0x00004000 with IROM_SPACE=4096 -> mem_cs=0; l_err pulses for 1 cycle; wr_count unchanged. Fetch read of the same address -> f_rvalid=1, f_err=1, f_rdata=0.
- Fetch read accepted, then rst=1 in the next cycle -> f_rvalid=0, all *_ready=0; after reset is released, fetch wins the first tie.
- 65536 in-range loader writes -> wr_count saturates at 0xFFFF.
